// File: rtl/regfile_arbiter_if.sv
// Bundle of every signal between the two requesters, the arbiter and the 8x16 register file.
//   req0_* / req1_*   : request handshake and fields from the core (0) and debug/loader (1) ports
//   rsp0_valid / rsp1_valid, rsp_data_a / rsp_data_b : one-cycle responses and shared captured data
//   rf_*              : register file address, write-enable and write-data pins, plus read data
// Modports: slave = the arbiter; master = requesters plus register file (environment side).
interface regfile_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr_a;
  logic [ADDR_W-1:0] req0_addr_b;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr_a;
  logic [ADDR_W-1:0] req1_addr_b;
  logic [DATA_W-1:0] req1_wdata;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;

  logic [ADDR_W-1:0] rf_address_a;
  logic [ADDR_W-1:0] rf_address_b;
  logic              rf_write_enable;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;

  modport slave (
    input  req0_valid, req0_write, req0_addr_a, req0_addr_b, req0_wdata,
    input  req1_valid, req1_write, req1_addr_a, req1_addr_b, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data_a, rsp_data_b,
    output rf_address_a, rf_address_b, rf_write_enable, rf_write_data,
    input  rf_data_a, rf_data_b
  );

  modport master (
    output req0_valid, req0_write, req0_addr_a, req0_addr_b, req0_wdata,
    output req1_valid, req1_write, req1_addr_a, req1_addr_b, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data_a, rsp_data_b,
    input  rf_address_a, rf_address_b, rf_write_enable, rf_write_data,
    output rf_data_a, rf_data_b
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one 8x16 register file between the core port (0) and the
// debug/loader port (1). One access per three cycles: IDLE (accept) -> ISSUE (drive rf pins,
// write on the falling edge) -> CAPTURE (rf read data valid) -> IDLE with a one-cycle response.
// Ports:
//   clk   : clock, rising-edge state updates
//   rst_n : asynchronous active-low reset
//   bus   : regfile_arbiter_if.slave carrying both request ports, the responses and rf pins
module regfile_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  regfile_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp0_q;
  logic              rsp1_q;
  logic [DATA_W-1:0] rsp_a_q;
  logic [DATA_W-1:0] rsp_b_q;

  logic              idle;
  logic              sel;
  logic              ready0;
  logic              ready1;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr_a;
  logic [ADDR_W-1:0] sel_addr_b;
  logic [DATA_W-1:0] sel_wdata;

  assign idle = (state_q == StIdle);

  // A lone valid port wins outright; rr_ptr only breaks ties.
  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel = rr_ptr_q;
    end else if (bus.req1_valid) begin
      sel = 1'b1;
    end
  end

  assign ready0 = idle & bus.req0_valid & ~sel;
  assign ready1 = idle & bus.req1_valid & sel;
  assign accept = ready0 | ready1;

  assign sel_write  = sel ? bus.req1_write  : bus.req0_write;
  assign sel_addr_a = sel ? bus.req1_addr_a : bus.req0_addr_a;
  assign sel_addr_b = sel ? bus.req1_addr_b : bus.req0_addr_b;
  assign sel_wdata  = sel ? bus.req1_wdata  : bus.req0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
      rsp_a_q  <= '0;
      rsp_b_q  <= '0;
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            grant_q  <= sel;
            addr_a_q <= sel_addr_a;
            addr_b_q <= sel_addr_b;
            we_q     <= sel_write;
            wdata_q  <= sel_wdata;
            rr_ptr_q <= ~sel;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          // Write (if any) happened on this cycle's falling edge; drop it before CAPTURE.
          we_q    <= 1'b0;
          state_q <= StCapture;
        end
        StCapture: begin
          rsp_a_q <= bus.rf_data_a;
          rsp_b_q <= bus.rf_data_b;
          rsp0_q  <= ~grant_q;
          rsp1_q  <= grant_q;
          state_q <= StIdle;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req0_ready      = ready0;
  assign bus.req1_ready      = ready1;
  assign bus.rf_address_a    = addr_a_q;
  assign bus.rf_address_b    = addr_b_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_data   = wdata_q;
  assign bus.rsp0_valid      = rsp0_q;
  assign bus.rsp1_valid      = rsp1_q;
  assign bus.rsp_data_a      = rsp_a_q;
  assign bus.rsp_data_b      = rsp_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a vector table of single-port accesses plus hand-written sequences
// for round-robin contention, lone-port grant, and reset during CAPTURE. Includes a behavioural
// register file (read sampled on rising edge, write on falling edge).
module tb_regfile_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regfile_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file environment model.
  logic [15:0] mem [0:7] = '{default: 16'h0000};
  always @(posedge clk) begin
    bus.rf_data_a <= mem[bus.rf_address_a];
    bus.rf_data_b <= mem[bus.rf_address_b];
  end
  always @(negedge clk) begin
    if (bus.rf_write_enable) mem[bus.rf_address_a] <= bus.rf_write_data;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rspv(input bit p);
    return p ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic drive(input bit p, input bit v, input bit w, input logic [2:0] a,
                       input logic [2:0] b, input logic [15:0] wd);
    if (p) begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr_a = a;
      bus.req1_addr_b = b; bus.req1_wdata = wd;
    end else begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr_a = a;
      bus.req0_addr_b = b; bus.req0_wdata = wd;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          port;
    bit          write;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] wd;
    bit          mangle;  // change fields right after accept
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v, input int idx);
    int n = 0;
    @(negedge clk);
    drive(v.port, 1'b1, v.write, v.a, v.b, v.wd);
    #1;
    while (!rdy(v.port) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d_ready", idx), rdy(v.port), 1);
    chk($sformatf("v%0d_other_ready", idx), rdy(!v.port), 0);
    if (!rdy(v.port)) begin
      drive(v.port, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
      return;
    end
    @(negedge clk);  // ISSUE
    if (v.mangle) drive(v.port, 1'b0, v.write, 3'd6, 3'd6, 16'hDEAD);
    else          drive(v.port, 1'b0, v.write, v.a, v.b, v.wd);
    chk($sformatf("v%0d_issue_we", idx), bus.rf_write_enable, v.write);
    chk($sformatf("v%0d_issue_addr_a", idx), bus.rf_address_a, v.a);
    chk($sformatf("v%0d_issue_addr_b", idx), bus.rf_address_b, v.b);
    if (v.write) chk($sformatf("v%0d_issue_wdata", idx), bus.rf_write_data, v.wd);
    #1;
    chk($sformatf("v%0d_issue_readies", idx), {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(negedge clk);  // CAPTURE
    chk($sformatf("v%0d_capture_we", idx), bus.rf_write_enable, 0);
    chk($sformatf("v%0d_capture_addr_a", idx), bus.rf_address_a, v.a);
    chk($sformatf("v%0d_capture_rsp", idx), {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    @(negedge clk);  // response cycle
    chk($sformatf("v%0d_rsp_own", idx), rspv(v.port), 1);
    chk($sformatf("v%0d_rsp_other", idx), rspv(!v.port), 0);
    chk($sformatf("v%0d_rsp_data_a", idx), bus.rsp_data_a, v.exp_a);
    chk($sformatf("v%0d_rsp_data_b", idx), bus.rsp_data_b, v.exp_b);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_one_cycle", idx), rspv(v.port), 0);
  endtask

  initial begin
    logic e0, e1, er0, er1;
    int n;
    vecs[0] = '{1'b0, 1'b1, 3'd3, 3'd5, 16'hBEEF, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 3'd3, 3'd3, 16'h0000, 1'b0, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 3'd5, 3'd3, 16'h1234, 1'b0, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 3'd7, 3'd7, 16'hA5A5, 1'b0, 16'hA5A5, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 3'd5, 3'd7, 16'h0000, 1'b0, 16'h1234, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b1, 3'd0, 3'd5, 16'hFFFF, 1'b0, 16'hFFFF, 16'h1234};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 3'd3, 16'h0000, 1'b0, 16'hFFFF, 16'hBEEF};
    vecs[7] = '{1'b0, 1'b1, 3'd2, 3'd2, 16'h5A5A, 1'b1, 16'h5A5A, 16'h5A5A};
    vecs[8] = '{1'b0, 1'b0, 3'd2, 3'd6, 16'h0000, 1'b0, 16'h5A5A, 16'h0000};

    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);

    // Reset state.
    #12;
    chk("reset_we", bus.rf_write_enable, 0);
    chk("reset_addr", {bus.rf_address_a, bus.rf_address_b}, 6'd0);
    chk("reset_wdata", bus.rf_write_data, 0);
    chk("reset_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    chk("reset_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Both ports valid continuously: grants 0,1,0,1 every third cycle.
    reset_pulse();
    drive(1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 16'h0);
    #1;
    for (int i = 0; i < 12; i++) begin
      e0  = (i % 3 == 0) && ((i / 3) % 2 == 0);
      e1  = (i % 3 == 0) && ((i / 3) % 2 == 1);
      er0 = (i % 3 == 0) && (i >= 3) && (((i / 3) - 1) % 2 == 0);
      er1 = (i % 3 == 0) && (i >= 3) && (((i / 3) - 1) % 2 == 1);
      chk($sformatf("rr_c%0d_ready0", i), bus.req0_ready, e0);
      chk($sformatf("rr_c%0d_ready1", i), bus.req1_ready, e1);
      chk($sformatf("rr_c%0d_rsp0", i), bus.rsp0_valid, er0);
      chk($sformatf("rr_c%0d_rsp1", i), bus.rsp1_valid, er1);
      if (er0) chk($sformatf("rr_c%0d_data", i), {bus.rsp_data_a, bus.rsp_data_b},
                   {16'hBEEF, 16'hFFFF});
      if (er1) chk($sformatf("rr_c%0d_data", i), {bus.rsp_data_a, bus.rsp_data_b},
                   {16'h1234, 16'hA5A5});
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);

    // Lone port 1 while rr_ptr favours port 0, then a tie goes to port 0.
    reset_pulse();
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 16'h0);
    #1;
    chk("lone1_ready1", bus.req1_ready, 1);
    chk("lone1_ready0", bus.req0_ready, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lone1_rsp1", bus.rsp1_valid, 1);
    chk("lone1_data_a", bus.rsp_data_a, 16'h1234);
    drive(1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 16'h0);
    #1;
    chk("tie_after_lone1_ready0", bus.req0_ready, 1);
    chk("tie_after_lone1_ready1", bus.req1_ready, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("tie_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b10);
    chk("tie_data_a", bus.rsp_data_a, 16'hBEEF);

    // Reset during CAPTURE of a read.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", bus.rf_write_enable, 0);
    chk("midrst_addr", {bus.rf_address_a, bus.rf_address_b}, 6'd0);
    chk("midrst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    chk("midrst_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) n++;
    end
    chk("midrst_no_rsp", n, 0);
    drive(1'b0, 1'b1, 1'b0, 3'd5, 3'd7, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 16'h0);
    #1;
    chk("postrst_ready0", bus.req0_ready, 1);
    chk("postrst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("postrst_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b10);
    chk("postrst_data", {bus.rsp_data_a, bus.rsp_data_b}, {16'h1234, 16'hA5A5});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the 8x16 register file between two requesters: port 0 is the core datapath, port 1 is the debug/loader path.
- Grants one request at a time using round-robin, then drives the register file address, write-enable and write-data pins itself.
- Captures data_a/data_b and returns them to the winning requester with a one-cycle response pulse.
- Sits between the requesters and the register file; the register file's ports connect only to this block.

Parameters:
- DATA_W, 16, register width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle (handshake = valid & ready at rising edge).
- req0_write / req1_write  in  1  1 = write wdata to addr_a; 0 = read only.
- req0_addr_a / req1_addr_a  in  ADDR_W  read address A; also the write address.
- req0_addr_b / req1_addr_b  in  ADDR_W  read address B.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse to the owning port.
- rsp_data_a  out  DATA_W  captured register file data_a (shared by both ports; qualified by rspN_valid).
- rsp_data_b  out  DATA_W  captured register file data_b.
- rf_address_a / rf_address_b  out  ADDR_W  to register file.
- rf_write_enable  out  1  to register file.
- rf_write_data  out  DATA_W  to register file.
- rf_data_a / rf_data_b  in  DATA_W  from register file.

Behaviour:
- Register file contract: it samples the addresses and updates data_a/data_b on the rising clk edge. It writes address_a on the falling edge while write_enable=1. A write issued in a cycle is therefore visible to the read at the end of that same cycle.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE
  - req_ready is combinational.
  - Only the port selected by round-robin and having valid=1 sees ready=1.
  - Selection: if only one port is valid, that port wins. If both are valid, the port named by rr_ptr wins.
  - On accept: latch grant id, write, addr_a, addr_b and wdata into the rf_* output registers; go to ISSUE.
  - rr_ptr <= ~granted id.
- ISSUE (exactly 1 cycle)
  - rf_address_a/b hold the latched addresses.
  - rf_write_enable = latched write; rf_write_data = latched wdata.
  - Register file samples the addresses at the rising edge that ends this cycle.
  - Next state: CAPTURE.
- CAPTURE (exactly 1 cycle)
  - rf_write_enable = 0; addresses are held.
  - At the rising edge that ends this cycle: rsp_data_a <= rf_data_a, rsp_data_b <= rf_data_b; rspN_valid <= 1 for the granted port only.
  - Next state: IDLE.
- rspN_valid is high for exactly one cycle, the first IDLE cycle after CAPTURE. A new accept may occur in that same cycle.
- Write requests also produce a response. rsp_data_a equals the written value (read-back); rsp_data_b is the value at addr_b after the write. If addr_b == addr_a, rsp_data_b also equals wdata.
- Throughput: one access per 3 cycles. Accept-to-rsp_valid latency: rsp_valid is high in cycle T+3, where T is the rising edge at which the handshake is sampled.
- Requesters hold valid and request fields stable until ready. Fields are sampled only at the accept edge; changes after accept do not affect the access.
- ready is never asserted outside IDLE; both readies are 0 in ISSUE and CAPTURE.
- req_valid dropped before accept: request silently withdrawn; no response.
- rf_write_enable is asserted only in ISSUE, and only for write requests; never asserted for more than one cycle per accept.
- Reset values (async, rst_n=0), taking effect immediately:
  - state=IDLE, rr_ptr=0 (port 0 favoured first).
  - rf_write_enable=0, rf_address_a/b=0, rf_write_data=0.
  - rsp0_valid=rsp1_valid=0, rsp_data_a/b=0.
- Reset asserted mid-ISSUE: the in-flight write may be lost, or may already have been performed at the falling edge. No response is generated and no request is retained.

Test Plan:
- Port 0 write addr_a=3 wdata=0xBEEF addr_b=5 -> rf_write_enable high exactly one cycle (T+1), rf_address_a=3; rsp0_valid pulses at T+3 with rsp_data_a=0xBEEF; rsp1_valid stays 0.
- Port 1 read addr_a=3 addr_b=3 after the write above -> rsp1_valid at T+3, rsp_data_a=rsp_data_b=0xBEEF, rf_write_enable stays 0.
- Both ports valid continuously from reset -> grants alternate 0,1,0,1 with exactly one accept every 3 cycles; each rspN_valid goes only to its owner.
- Only port 1 valid while rr_ptr points to port 0 -> port 1 accepted immediately; next simultaneous request is granted to port 0.
- Port 0 changes addr_a/wdata in the cycle after accept -> response and register file contents reflect the originally accepted values.
- rst_n pulsed low during CAPTURE of a read -> rf_write_enable, rsp*_valid and rsp_data drop to 0 immediately; FSM in IDLE; no response after release; next request behaves normally with port 0 favoured.
